// File: rtl/clarvi_pio_pkg.sv
// Shared definitions for the Clarvi output PIO: register map and STATUS layout.
package clarvi_pio_pkg;

  // Word addresses of the PIO register file.
  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_SET    = 3'd1,
    ADDR_CLEAR  = 3'd2,
    ADDR_TOGGLE = 3'd3,
    ADDR_MASK   = 3'd4,
    ADDR_PERIOD = 3'd5,
    ADDR_STATUS = 3'd6,
    ADDR_RSVD   = 3'd7
  } reg_addr_e;

  // Bit positions inside the STATUS word.
  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

  // Assemble the 32-bit STATUS word; all unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic phase, input logic active);
    logic [31:0] s;
    s                    = 32'd0;
    s[STATUS_PHASE_BIT]  = phase;
    s[STATUS_ACTIVE_BIT] = active;
    return s;
  endfunction

endpackage

// File: rtl/clarvi_pio_blink_timer.sv
// Blink timer: free-running half-period counter and phase flag.
// Phase toggles every i_period cycles; a period of zero parks everything at 0.
module clarvi_pio_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_restart,
  output logic                o_phase
);

  logic [PERIOD_W-1:0] r_count;
  logic                r_phase;
  logic [PERIOD_W-1:0] w_count_nxt;
  logic                w_phase_nxt;
  logic                w_wrap;

  // The counter normally never exceeds period-1 (any period change restarts it);
  // the >= compare makes a corrupted counter recover at the next cycle anyway.
  assign w_wrap = (r_count >= (i_period - PERIOD_W'(1)));

  // Next-state for counter and phase: restart, disable, wrap or count.
  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (i_restart) begin
      w_count_nxt = {PERIOD_W{1'b0}};
      w_phase_nxt = 1'b0;
    end else if (i_period == {PERIOD_W{1'b0}}) begin
      w_count_nxt = {PERIOD_W{1'b0}};
      w_phase_nxt = 1'b0;
    end else if (w_wrap) begin
      w_count_nxt = {PERIOD_W{1'b0}};
      w_phase_nxt = ~r_phase;
    end else begin
      w_count_nxt = r_count + PERIOD_W'(1);
      w_phase_nxt = r_phase;
    end
  end

  // Counter and phase registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {PERIOD_W{1'b0}};
      r_phase <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/clarvi_pio_out_blink.sv
// Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE registers and a hardware
// blink engine that inverts the BLINK_MASK bits of the output each half-period.
module clarvi_pio_out_blink
  import clarvi_pio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mask;
  logic [PERIOD_W-1:0] r_period;

  logic [WIDTH-1:0]    w_data_nxt;
  logic [WIDTH-1:0]    w_mask_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic                w_wr;
  logic                w_restart;
  logic                w_phase;
  logic                w_active;
  logic [WIDTH-1:0]    w_wd_data;
  logic [PERIOD_W-1:0] w_wd_period;
  logic                w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd_data   = writedata[WIDTH-1:0];
  assign w_wd_period = writedata[PERIOD_W-1:0];
  // Upper write-data bits are deliberately ignored.
  assign w_unused_wd = ^writedata;

  // Any BLINK_PERIOD write starts the new period from phase 0.
  assign w_restart = w_wr & (reg_addr_e'(address) == ADDR_PERIOD);
  assign w_active  = (r_period != {PERIOD_W{1'b0}}) & (r_mask != {WIDTH{1'b0}});

  clarvi_pio_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_period  (r_period),
    .i_restart (w_restart),
    .o_phase   (w_phase)
  );

  // Register-file next state: decode the write address and apply the update.
  always_comb begin
    w_data_nxt   = r_data;
    w_mask_nxt   = r_mask;
    w_period_nxt = r_period;
    if (w_wr) begin
      case (reg_addr_e'(address))
        ADDR_DATA:   w_data_nxt   = w_wd_data;
        ADDR_SET:    w_data_nxt   = r_data | w_wd_data;
        ADDR_CLEAR:  w_data_nxt   = r_data & ~w_wd_data;
        ADDR_TOGGLE: w_data_nxt   = r_data ^ w_wd_data;
        ADDR_MASK:   w_mask_nxt   = w_wd_data;
        ADDR_PERIOD: w_period_nxt = w_wd_period;
        default: begin
          w_data_nxt   = r_data;
          w_mask_nxt   = r_mask;
          w_period_nxt = r_period;
        end
      endcase
    end else begin
      w_data_nxt   = r_data;
      w_mask_nxt   = r_mask;
      w_period_nxt = r_period;
    end
  end

  // Register file; reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_mask   <= {WIDTH{1'b0}};
      r_period <= {PERIOD_W{1'b0}};
    end else begin
      r_data   <= w_data_nxt;
      r_mask   <= w_mask_nxt;
      r_period <= w_period_nxt;
    end
  end

  // Zero-wait-state read mux; unused upper bits read as zero.
  always_comb begin
    readdata = 32'd0;
    case (reg_addr_e'(address))
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: readdata = 32'(r_data);
      ADDR_MASK:   readdata = 32'(r_mask);
      ADDR_PERIOD: readdata = 32'(r_period);
      ADDR_STATUS: readdata = pack_status(w_phase, w_active);
      ADDR_RSVD:   readdata = 32'd0;
      default:     readdata = 32'd0;
    endcase
  end

  // Output pins: base value with masked bits inverted during phase 1.
  assign out_port = r_data ^ (r_mask & {WIDTH{w_phase}});

endmodule

// File: tb/tb_clarvi_pio_out_blink.sv
// Self-checking bench for clarvi_pio_out_blink: directed register-map and blink
// scenarios followed by randomized bus traffic, compared against a reference
// model where phase is derived from cycles elapsed since the last restart.
module tb_clarvi_pio_out_blink;

  localparam int             W  = 10;
  localparam int             PW = 24;
  localparam logic [W-1:0]   RV = 10'h155;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_mask;
  logic [PW-1:0] m_period;
  longint        m_elapsed;

  always #5 clk = ~clk;

  clarvi_pio_out_blink #(
    .WIDTH       (W),
    .PERIOD_W    (PW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Phase = parity of the number of whole half-periods elapsed since restart.
  function automatic logic m_phase();
    if (m_period == '0) return 1'b0;
    return ((m_elapsed / longint'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_out();
    return 32'(m_data ^ (m_phase() ? m_mask : {W{1'b0}}));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
      3'd4: return 32'(m_mask);
      3'd5: return 32'(m_period);
      3'd6: return {30'd0, (m_period != '0) && (m_mask != '0), m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: advance the model with the inputs held across the edge,
  // then check the output pins and the combinational read at the current address.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_data    = RV;
      m_mask    = '0;
      m_period  = '0;
      m_elapsed = 0;
    end else begin
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data   = writedata[W-1:0];
          3'd1: m_data   = m_data | writedata[W-1:0];
          3'd2: m_data   = m_data & ~writedata[W-1:0];
          3'd3: m_data   = m_data ^ writedata[W-1:0];
          3'd4: m_mask   = writedata[W-1:0];
          3'd5: m_period = writedata[PW-1:0];
          default: ;
        endcase
      end
      if (chipselect && !write_n && address == 3'd5) m_elapsed = 0;
      else m_elapsed++;
    end
    #1;
    check("out_port", 32'(out_port), m_out());
    check("readdata", readdata, m_read(address));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    check("rst_out", 32'(out_port), 32'h155);
    rd_expect("rst_data", 3'd0, 32'h155);
    rd_expect("rst_mask", 3'd4, 32'h0);
    rd_expect("rst_period", 3'd5, 32'h0);
    rd_expect("rst_status", 3'd6, 32'h0);
    step();

    // Atomic data operations
    wr(3'd0, 32'h0F0);
    check("wr_data_out", 32'(out_port), 32'h0F0);
    wr(3'd1, 32'h003);
    check("wr_set_out", 32'(out_port), 32'h0F3);
    wr(3'd2, 32'h010);
    check("wr_clr_out", 32'(out_port), 32'h0E3);
    wr(3'd3, 32'h300);
    check("wr_tgl_out", 32'(out_port), 32'h3E3);
    rd_expect("data_3e3", 3'd0, 32'h3E3);

    // Blink bit0 with half-period 4
    wr(3'd4, 32'h001);
    wr(3'd5, 32'd4);
    rd_expect("blink_status0", 3'd6, 32'h2);
    steps(4);
    check("blink_out_ph1", 32'(out_port), 32'h3E2);
    rd_expect("blink_status1", 3'd6, 32'h3);
    steps(4);
    check("blink_out_ph0", 32'(out_port), 32'h3E3);
    steps(9);

    // Disable blinking
    wr(3'd5, 32'd0);
    rd_expect("dis_status", 3'd6, 32'h0);
    steps(5);
    check("dis_out", 32'(out_port), 32'h3E3);

    // Mid-blink period rewrite
    wr(3'd5, 32'd2);
    steps(2);
    rd_expect("mid_ph1", 3'd6, 32'h3);
    wr(3'd5, 32'd2);
    rd_expect("mid_restart", 3'd6, 32'h2);
    step();
    rd_expect("mid_hold", 3'd6, 32'h2);
    step();
    rd_expect("mid_toggle", 3'd6, 32'h3);
    step();

    // Reset mid-blink with a simultaneous DATA write
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'h000;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset      = 1'b0;
    check("rst2_out", 32'(out_port), 32'h155);
    rd_expect("rst2_data", 3'd0, 32'h155);
    rd_expect("rst2_mask", 3'd4, 32'h0);
    rd_expect("rst2_period", 3'd5, 32'h0);
    step();

    // Upper write-data bits ignored; reserved address reads zero
    wr(3'd0, 32'hFFFF_FFFF);
    rd_expect("wide_data", 3'd0, 32'h0000_03FF);
    rd_expect("addr7", 3'd7, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_expect("addr7_wr", 3'd7, 32'h0);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 80) == 0);
      chipselect = $urandom_range(0, 1);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 3'($urandom_range(0, 7));
      if (address == 3'd5 && $urandom_range(0, 5) != 0)
        writedata = $urandom_range(0, 5);
      else
        writedata = $urandom;
      step();
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
